// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: fixed-latency line store arbitrating icache fills and dcache fills/writebacks
module main_mem_ctrl #(
  parameter int LINE_W      = 128,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, ACK} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ic_ack_q, dc_ack_q, busy_q;
  logic [LINE_W-1:0] ic_rdata_q, dc_rdata_q;
  logic [LINE_W-1:0] mem_q [DEPTH_LINES];
  logic              done, fin_i, fin_d;
  logic              unused_addr;
  assign unused_addr = ^{ic_addr[ADDR_W-1:IDX_W+4], ic_addr[3:0], dc_addr[ADDR_W-1:IDX_W+4], dc_addr[3:0]};
  assign done  = cnt_q == 4'(LATENCY);
  assign fin_i = state_q == SERVE_I && done;
  assign fin_d = state_q == SERVE_D && done;
  assign ic_ack   = ic_ack_q;
  assign dc_ack   = dc_ack_q;
  assign busy     = busy_q;
  assign ic_rdata = ic_rdata_q;
  assign dc_rdata = dc_rdata_q;
  // next state: dcache wins arbitration in IDLE; request inputs are latched once and then ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (dc_req) begin
          state_d = SERVE_D;
          cnt_d   = 4'd1;
          idx_d   = dc_addr[IDX_W+3:4];
          we_d    = dc_we;
          wdata_d = dc_wdata;
        end else if (ic_req) begin
          state_d = SERVE_I;
          cnt_d   = 4'd1;
          idx_d   = ic_addr[IDX_W+3:4];
          we_d    = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        cnt_d   = done ? 4'd0 : cnt_q + 4'd1;
        state_d = done ? ACK : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, latched request and registered outputs; reset aborts any transaction silently
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      ic_ack_q <= fin_i;
      dc_ack_q <= fin_d;
      busy_q   <= state_d != IDLE;
      if (fin_i) ic_rdata_q <= mem_q[idx_q];
      if (fin_d && !we_q) dc_rdata_q <= mem_q[idx_q];
    end
  end
  // backing store: writeback commits only at completion, so a reset beforehand drops it
  always_ff @(posedge clock) begin
    if (reset && fin_d && we_q) mem_q[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl: directed stimulus against a transaction-level timing and memory model
module tb_main_mem_ctrl;
  localparam int LAT = 4;
  localparam int DEPTH = 256;
  logic         clock = 1'b0;
  logic         reset;
  logic         ic_req, dc_req, dc_we;
  logic [31:0]  ic_addr, dc_addr;
  logic [127:0] dc_wdata;
  logic         ic_ack, dc_ack, busy;
  logic [127:0] ic_rdata, dc_rdata;
  int           total = 0;
  int           passed = 0;

  main_mem_ctrl #(.LINE_W(128), .ADDR_W(32), .DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask

  // model: a transaction accepted at edge a acks after edge a+LAT, frees the controller at a+LAT+2
  int           e = 0;
  int           next_free = 0;
  bit           txn = 0;
  bit           t_d, t_we;
  int           t_idx, t_acc;
  logic [127:0] t_wd;
  logic [127:0] mm [int];
  logic         m_busy, m_ica, m_dca;
  logic [127:0] m_ir, m_dr;

  always @(posedge clock) begin
    e++;
    if (!reset) begin
      txn = 0; next_free = e + 1;
      m_busy = 0; m_ica = 0; m_dca = 0; m_ir = '0; m_dr = '0;
    end else begin
      m_ica = 0; m_dca = 0;
      if (txn && e == t_acc + LAT) begin
        if (t_d && t_we) mm[t_idx] = t_wd;
        else if (t_d) m_dr = mm.exists(t_idx) ? mm[t_idx] : 'x;
        else m_ir = mm.exists(t_idx) ? mm[t_idx] : 'x;
        if (t_d) m_dca = 1; else m_ica = 1;
      end
      if (txn && e == t_acc + LAT + 1) txn = 0;
      if (!txn && e >= next_free && (dc_req || ic_req)) begin
        txn = 1; t_d = dc_req; t_we = dc_req && dc_we; t_wd = dc_wdata; t_acc = e;
        t_idx = int'(((dc_req ? dc_addr : ic_addr) >> 4) % DEPTH);
        next_free = e + LAT + 2;
      end
      m_busy = txn && e >= t_acc && e <= t_acc + LAT;
    end
  end

  always @(negedge clock) if (e > 0) begin
    chk("ic_ack", ic_ack, m_ica);
    chk("dc_ack", dc_ack, m_dca);
    chk("busy", busy, m_busy);
    chk("ic_rdata", ic_rdata, m_ir);
    chk("dc_rdata", dc_rdata, m_dr);
  end

  task automatic dc_txn(input logic we, input logic [31:0] a, input logic [127:0] wd,
                        input logic [31:0] mid_a, input bit keep, output int lat);
    dc_req = 1; dc_we = we; dc_addr = a; dc_wdata = wd; lat = 0;
    do begin
      @(negedge clock); lat++;
      if (lat == 1) dc_addr = mid_a;
    end while (!dc_ack && lat < 40);
    chk("dc_ack_seen", dc_ack, 1'b1);
    if (!keep) dc_req = 0;
  endtask

  task automatic ic_txn(input logic [31:0] a, output int lat);
    ic_req = 1; ic_addr = a; lat = 0;
    do begin @(negedge clock); lat++; end while (!ic_ack && lat < 40);
    chk("ic_ack_seen", ic_ack, 1'b1);
    ic_req = 0;
  endtask

  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D3 = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;
  localparam logic [127:0] DA = {16{8'hA5}};

  initial begin
    int lat, k, dk, ik, bcnt, acks;
    reset = 0; ic_req = 1; dc_req = 1; dc_we = 1; ic_addr = '0; dc_addr = '0; dc_wdata = D1;
    repeat (3) @(negedge clock);
    chk("rst_ic_ack", ic_ack, 0);
    chk("rst_dc_ack", dc_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ic_rdata", ic_rdata, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    acks = 0;
    repeat (10) begin @(negedge clock); acks += int'(ic_ack) + int'(dc_ack); end
    chk("rst_no_ack", 128'(acks), 0);
    ic_req = 0; dc_req = 0; dc_we = 0;
    @(negedge clock); reset = 1;
    @(negedge clock);
    dc_txn(1, 32'h40, D1, 32'h40, 0, lat);
    chk("wb_latency", 128'(lat), 128'(LAT + 1));
    @(negedge clock);
    dc_txn(0, 32'h40, '0, 32'h40, 0, lat);
    chk("fill_0x40", dc_rdata, D1);
    @(negedge clock);
    dc_txn(1, 32'h80, D2, 32'h80, 0, lat);
    @(negedge clock);
    ic_txn(32'h8C, lat);
    chk("ic_fill_0x8c", ic_rdata, D2);
    chk("dc_rdata_kept", dc_rdata, D1);
    @(negedge clock);
    ic_req = 1; ic_addr = 32'h40; dc_req = 1; dc_we = 0; dc_addr = 32'h80;
    k = 0; dk = 0; ik = 0; bcnt = 0;
    while (ik == 0 && k < 60) begin
      @(negedge clock); k++;
      bcnt += int'(busy);
      if (dc_ack) begin dk = k; dc_req = 0; end
      if (ic_ack) begin ik = k; ic_req = 0; end
    end
    chk("sim_dc_first", 128'(dk), 128'(LAT + 1));
    chk("sim_ic_gap", 128'(ik - dk), 128'(LAT + 2));
    chk("sim_busy_cnt", 128'(bcnt), 128'(ik - 1));
    chk("sim_dc_data", dc_rdata, D2);
    chk("sim_ic_data", ic_rdata, D1);
    @(negedge clock);
    dc_txn(1, 32'h1000, DA, 32'h1000, 0, lat);
    @(negedge clock);
    dc_txn(0, 32'h0, '0, 32'h80, 0, lat);
    chk("alias_mid_addr", dc_rdata, DA);
    @(negedge clock);
    dc_req = 1; dc_we = 1; dc_addr = 32'h40; dc_wdata = D3;
    @(negedge clock);
    reset = 0; dc_req = 0;
    acks = int'(dc_ack);
    @(negedge clock);
    reset = 1;
    repeat (LAT + 3) begin @(negedge clock); acks += int'(dc_ack); end
    chk("abort_no_ack", 128'(acks), 0);
    dc_txn(0, 32'h40, '0, 32'h40, 0, lat);
    chk("abort_old_line", dc_rdata, D1);
    @(negedge clock);
    dc_txn(0, 32'h40, '0, 32'h40, 1, lat);
    chk("b2b_d0", dc_rdata, D1);
    dc_txn(0, 32'h80, '0, 32'h80, 1, lat);
    chk("b2b_period1", 128'(lat), 128'(LAT + 2));
    chk("b2b_d1", dc_rdata, D2);
    dc_txn(0, 32'h0, '0, 32'h0, 0, lat);
    chk("b2b_period2", 128'(lat), 128'(LAT + 2));
    chk("b2b_d2", dc_rdata, DA);
    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
